// File: rtl/rs_wakeup_station_if.sv
// Dispatch, CDB and issue signals of rs_wakeup_station.
// The master side drives dispatch, the CDB and issue_ready; the slave side is the station.
interface rs_wakeup_station_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 6
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush;

  logic              push_valid;
  logic              push_ready;
  logic [OP_W-1:0]   push_op;
  logic [TAG_W-1:0]  push_tag1;
  logic [TAG_W-1:0]  push_tag2;
  logic [DATA_W-1:0] push_val1;
  logic [DATA_W-1:0] push_val2;
  logic [TAG_W-1:0]  push_target;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  logic              issue_valid;
  logic              issue_ready;
  logic [OP_W-1:0]   issue_op;
  logic [DATA_W-1:0] issue_val1;
  logic [DATA_W-1:0] issue_val2;
  logic [TAG_W-1:0]  issue_target;

  logic [CNT_W-1:0]  count;

  modport master (
    output flush,
    output push_valid, push_op, push_tag1, push_tag2, push_val1, push_val2, push_target,
    input  push_ready,
    output cdb_valid, cdb_tag, cdb_data,
    output issue_ready,
    input  issue_valid, issue_op, issue_val1, issue_val2, issue_target,
    input  count
  );

  modport slave (
    input  flush,
    input  push_valid, push_op, push_tag1, push_tag2, push_val1, push_val2, push_target,
    output push_ready,
    input  cdb_valid, cdb_tag, cdb_data,
    input  issue_ready,
    output issue_valid, issue_op, issue_val1, issue_val2, issue_target,
    output count
  );
endinterface

// File: rtl/rs_wakeup_station.sv
// Reservation station: CDB operand wakeup, age-matrix oldest-ready select, flush.
// Optional RS_CDB_BYPASS_EN: a push captures a same-cycle CDB result for matching tags.
module rs_wakeup_station #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 6
) (
  input logic                clk,
  input logic                rst_n,
  rs_wakeup_station_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [OP_W-1:0]   op_q     [DEPTH];
  logic [OP_W-1:0]   op_d     [DEPTH];
  logic [TAG_W-1:0]  tag1_q   [DEPTH];
  logic [TAG_W-1:0]  tag1_d   [DEPTH];
  logic [TAG_W-1:0]  tag2_q   [DEPTH];
  logic [TAG_W-1:0]  tag2_d   [DEPTH];
  logic [DATA_W-1:0] val1_q   [DEPTH];
  logic [DATA_W-1:0] val1_d   [DEPTH];
  logic [DATA_W-1:0] val2_q   [DEPTH];
  logic [DATA_W-1:0] val2_d   [DEPTH];
  logic [TAG_W-1:0]  target_q [DEPTH];
  logic [TAG_W-1:0]  target_d [DEPTH];
  // older_q[i][j] set means entry i was pushed before entry j
  logic [DEPTH-1:0]  older_q  [DEPTH];
  logic [DEPTH-1:0]  older_d  [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DEPTH-1:0]  ready;
  logic [DEPTH-1:0]  older_ready;
  logic [DEPTH-1:0]  sel_oh;
  logic              push_fire;
  logic              issue_fire;
  logic [IDX_W-1:0]  push_idx;
  logic [TAG_W-1:0]  in_tag1, in_tag2;
  logic [DATA_W-1:0] in_val1, in_val2;

  assign bus.push_ready  = (count_q < DEPTH_C);
  assign bus.count       = count_q;
  assign bus.issue_valid = |ready;

  assign push_fire  = bus.push_valid  && bus.push_ready  && !bus.flush;
  assign issue_fire = bus.issue_valid && bus.issue_ready && !bus.flush;

  // Oldest ready entry: ready and no other ready entry is older than it.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    ready       = '0;
    older_ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = valid_q[i] && (tag1_q[i] == '0) && (tag2_q[i] == '0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (ready[j] && older_q[j][i]) older_ready[i] = 1'b1;
      end
    end
  end

  assign sel_oh = ready & ~older_ready;

  always_comb begin
    bus.issue_op     = '0;
    bus.issue_val1   = '0;
    bus.issue_val2   = '0;
    bus.issue_target = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) begin
        bus.issue_op     = op_q[i];
        bus.issue_val1   = val1_q[i];
        bus.issue_val2   = val2_q[i];
        bus.issue_target = target_q[i];
      end
    end
  end

  always_comb begin
    push_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) push_idx = IDX_W'(i);
    end
  end

  always_comb begin
    in_tag1 = bus.push_tag1;
    in_tag2 = bus.push_tag2;
    in_val1 = bus.push_val1;
    in_val2 = bus.push_val2;
`ifdef RS_CDB_BYPASS_EN
    if (bus.cdb_valid && bus.push_tag1 != '0 && bus.push_tag1 == bus.cdb_tag) begin
      in_tag1 = '0;
      in_val1 = bus.cdb_data;
    end
    if (bus.cdb_valid && bus.push_tag2 != '0 && bus.push_tag2 == bus.cdb_tag) begin
      in_tag2 = '0;
      in_val2 = bus.cdb_data;
    end
`else
    // Dispatch never offers a tag that is on the CDB in the same cycle.
    in_tag1 = bus.push_tag1;
`endif
  end

  always_comb begin
    valid_d  = valid_q;
    op_d     = op_q;
    tag1_d   = tag1_q;
    tag2_d   = tag2_q;
    val1_d   = val1_q;
    val2_d   = val2_q;
    target_d = target_q;
    older_d  = older_q;

    // Tag 0 never matches, so already-present operands are never overwritten.
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.cdb_valid && valid_q[i] && tag1_q[i] != '0 && tag1_q[i] == bus.cdb_tag) begin
        tag1_d[i] = '0;
        val1_d[i] = bus.cdb_data;
      end
      if (bus.cdb_valid && valid_q[i] && tag2_q[i] != '0 && tag2_q[i] == bus.cdb_tag) begin
        tag2_d[i] = '0;
        val2_d[i] = bus.cdb_data;
      end
    end

    if (issue_fire) valid_d = valid_d & ~sel_oh;

    if (push_fire) begin
      valid_d[push_idx]  = 1'b1;
      op_d[push_idx]     = bus.push_op;
      tag1_d[push_idx]   = in_tag1;
      tag2_d[push_idx]   = in_tag2;
      val1_d[push_idx]   = in_val1;
      val2_d[push_idx]   = in_val2;
      target_d[push_idx] = bus.push_target;
      older_d[push_idx]  = '0;
      for (int j = 0; j < DEPTH; j++) begin
        older_d[j][push_idx] = valid_q[j];
      end
    end

    count_d = count_q + CNT_W'(push_fire) - CNT_W'(issue_fire);

    if (bus.flush) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!rst_n) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // NOTE: payload and age matrix are only read through valid_q, so they carry no reset.
  always_ff @(posedge clk) begin
    op_q     <= op_d;
    tag1_q   <= tag1_d;
    tag2_q   <= tag2_d;
    val1_q   <= val1_d;
    val2_q   <= val2_d;
    target_q <= target_d;
    older_q  <= older_d;
  end
endmodule
